// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with a CPU-side byte buffer consumed on ack rising edges.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       ack,
  output logic       irr,
  output logic [7:0] r_data,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_rx: CLKS_PER_BIT must be >= 4 and FIFO_DEPTH a power of 2 >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_meta, r_rxs;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            w_expire, w_push, w_ferr, w_drop;
  logic            r_ack_q, w_pop;
  logic            r_overrun, r_frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_rxs  <= 1'b1;
    end else begin
      r_meta <= rx;
      r_rxs  <= r_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  assign w_expire = (r_cnt == '0);

  // Counter loads N-1 so expiry lands exactly N cycles after the load.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_expire ? r_cnt : r_cnt - 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = HALF_M1;
        end
      end
      S_START: begin
        if (w_expire) begin
          if (!r_rxs) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = FULL_M1;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_expire) begin
          w_shift_nxt[r_idx] = r_rxs;
          w_cnt_nxt          = FULL_M1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (w_expire) begin
          if (r_rxs) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_ack_q <= 1'b0;
    else       r_ack_q <= ack;
  end
  assign w_pop = ack & ~r_ack_q;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic        w_full, w_do_pop, w_do_push;

  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_do_pop  = w_pop & irr;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = w_push & (~w_full | w_do_pop);
  assign w_drop    = w_push & ~w_do_push;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign irr    = (r_count != '0);
  assign r_data = irr ? r_mem[r_rd] : 8'h00;
`else
  logic [7:0] r_hold;
  logic       r_valid;

  assign w_drop = w_push & r_valid & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
    end else if (w_push && (!r_valid || w_pop)) begin
      r_hold  <= r_shift;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign irr    = r_valid;
  assign r_data = r_valid ? r_hold : 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= w_drop;
      r_frame_err <= w_ferr;
    end
  end

  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a byte-queue reference model.
module tb_uart_rx;
  localparam int CPB = 16;
  // Drive iteration just before the push edge: 2 sync + 1 detect + half bit + 9 bits.
  localparam int PUSH_C = 2 + CPB/2 + 9*CPB;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, ack = 1'b0;
  logic       irr, overrun, frame_err;
  logic [7:0] r_data;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ack(ack),
    .irr(irr), .r_data(r_data), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_ovr = 0, n_ferr = 0, exp_ovr = 0, exp_ferr = 0;
  logic [7:0] q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (overrun)   n_ovr++;
      if (frame_err) n_ferr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_data();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, " irr"}, irr, q.size() != 0);
    chk({tag, " data"}, r_data, exp_data());
    chk({tag, " ovr"}, n_ovr, exp_ovr);
    chk({tag, " ferr"}, n_ferr, exp_ferr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  // One 10-bit frame; optionally raises ack so its edge coincides with the push.
  task automatic send(input logic [7:0] b, input logic stop, input bit ack_push);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 10*CPB; c++) begin
      if (c == PUSH_C) chk("pre-push irr", irr, q.size() != 0);
      if (c == PUSH_C + 1) begin
        if (ack_push && q.size() != 0) void'(q.pop_front());
        if (!stop)                 exp_ferr++;
        else if (q.size() < CAP)   q.push_back(b);
        else                       exp_ovr++;
        chk("push irr", irr, q.size() != 0);
        chk("push data", r_data, exp_data());
      end
      rx = bits[c/CPB];
      if (ack_push && c == PUSH_C) ack = 1'b1;
      tick();
    end
    if (ack_push) begin
      ack = 1'b0;
      tick();
    end
  endtask

  task automatic do_ack(input int hold);
    ack = 1'b1;
    tick();
    if (q.size() != 0) void'(q.pop_front());
    chk("ack irr", irr, q.size() != 0);
    chk("ack data", r_data, exp_data());
    repeat (hold - 1) tick();
    ack = 1'b0;
    tick();
    chk("held ack data", r_data, exp_data());
  endtask

  initial begin
    logic [9:0] fbits;
    logic [7:0] rb;
    logic       rs;

    repeat (3) tick();
    chk("reset irr", irr, 1'b0);
    chk("reset data", r_data, 8'h00);
    chk("reset ovr", overrun, 1'b0);
    chk("reset ferr", frame_err, 1'b0);
    reset = 1'b0;
    idle(5);

    // 1: basic frame and single-cycle ack
    send(8'hA5, 1'b1, 1'b0);
    check_state("t1");
    do_ack(1);
    check_state("t1 ack");

    // 2: start glitch, then a real frame
    rx = 1'b0;
    repeat (5) tick();
    idle(20);
    check_state("t2 glitch");
    send(8'h3C, 1'b1, 1'b0);
    check_state("t2");
    do_ack(2);

    // 3: framing error with line held in break
    send(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) tick();
    idle(20);
    check_state("t3 break");
    send(8'h55, 1'b1, 1'b0);
    check_state("t3");
    do_ack(1);

`ifdef UART_RX_FIFO_EN
    // 4: fill the FIFO past capacity, then drain with held acks
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1, 1'b0);
      idle(3);
    end
    check_state("t4 full");
    for (int i = 0; i < 4; i++) do_ack(5);
    check_state("t4 drained");
`else
    // 5: overrun on the holding register, then pop/push in the same cycle
    send(8'h11, 1'b1, 1'b0);
    idle(3);
    send(8'h22, 1'b1, 1'b0);
    idle(3);
    check_state("t5 ovr");
    send(8'h22, 1'b1, 1'b1);
    check_state("t5 swap");
    do_ack(3);
`endif

    // 6: reset after three data bits of 0xFF
    fbits = {1'b1, 8'hFF, 1'b0};
    for (int c = 0; c < 4*CPB; c++) begin
      rx = fbits[c/CPB];
      tick();
    end
    reset = 1'b1;
    rx = 1'b1;
    tick();
    q.delete();
    chk("t6 irr", irr, 1'b0);
    chk("t6 data", r_data, 8'h00);
    chk("t6 ovr", overrun, 1'b0);
    chk("t6 ferr", frame_err, 1'b0);
    reset = 1'b0;
    idle(30);
    send(8'h7E, 1'b1, 1'b0);
    check_state("t6");
    do_ack(1);

    // Randomized frames, framing errors and acks
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      send(rb, rs, 1'b0);
      if (!rs) begin
        rx = 1'b0;
        repeat ($urandom_range(1, 30)) tick();
        idle(10);
      end else begin
        idle($urandom_range(2, 10));
      end
      if ($urandom_range(0, 1) != 0) do_ack($urandom_range(1, 6));
      check_state("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
